// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: assembles 16-bit instructions from two byte reads,
// presents them to decode with a valid/ready handshake, and handles branches and halt.
module fetch_sequencer #(
   parameter logic [15:0] RESET_PC  = 16'h0000,
   parameter logic [15:0] HALT_WORD = 16'hFFFF
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        Run,
   output logic [15:0] Mem_Addr,
   output logic        Mem_Rd_En,
   input  logic [7:0]  Mem_Data,
   output logic [15:0] Instr_Out,
   output logic [15:0] Instr_PC,
   output logic        Instr_Valid,
   input  logic        Instr_Ready,
   input  logic        Branch_Taken,
   input  logic [15:0] Branch_Target,
   output logic        Halted
);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      FETCH_HI = 3'd1,
      FETCH_LO = 3'd2,
      LATCH    = 3'd3,
      PRESENT  = 3'd4,
      HALTED   = 3'd5
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic [15:0] pc;
   logic [15:0] pc_nxt;
   logic [7:0]  hi_byte;
   logic [15:0] word_c;
   logic [15:0] br_pc_c;

   // Low byte arrives on Mem_Data during LATCH; branch targets are forced even.
   assign word_c  = {hi_byte, Mem_Data};
   assign br_pc_c = Branch_Target & 16'hFFFE;

   // Next state and next PC; a branch outside IDLE overrides everything else.
   always_comb begin
      state_nxt = state;
      pc_nxt    = pc;
      if (state == IDLE) begin
         if (Branch_Taken) pc_nxt = br_pc_c;
         if (Run) state_nxt = FETCH_HI;
      end else if (Branch_Taken) begin
         pc_nxt    = br_pc_c;
         state_nxt = FETCH_HI;
      end else begin
         case (state)
            FETCH_HI: state_nxt = FETCH_LO;
            FETCH_LO: state_nxt = LATCH;
            LATCH:    state_nxt = (word_c == HALT_WORD) ? HALTED : PRESENT;
            PRESENT: begin
               if (Instr_Ready) begin
                  pc_nxt    = pc + 16'd2;
                  state_nxt = FETCH_HI;
               end
            end
            default:  state_nxt = state;
         endcase
      end
   end

   // State, PC, byte capture and registered outputs decoded from the next state.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state       <= IDLE;
         pc          <= RESET_PC;
         hi_byte     <= '0;
         Instr_Out   <= '0;
         Instr_PC    <= '0;
         Instr_Valid <= 1'b0;
         Halted      <= 1'b0;
         Mem_Rd_En   <= 1'b0;
         Mem_Addr    <= '0;
      end else begin
         state       <= state_nxt;
         pc          <= pc_nxt;
         Instr_Valid <= (state_nxt == PRESENT);
         Halted      <= (state_nxt == HALTED);
         Mem_Rd_En   <= (state_nxt == FETCH_HI) || (state_nxt == FETCH_LO);
         if (state_nxt == FETCH_HI)      Mem_Addr <= pc_nxt;
         else if (state_nxt == FETCH_LO) Mem_Addr <= pc_nxt + 16'd1;
         else                            Mem_Addr <= '0;
         if ((state == FETCH_LO) && !Branch_Taken) hi_byte <= Mem_Data;
         if ((state == LATCH) && (state_nxt == PRESENT)) begin
            Instr_Out <= word_c;
            Instr_PC  <= pc;
         end
      end
   end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios plus random traffic, checked by a
// transaction-level reference model feeding a scoreboard queue.
module tb_fetch_sequencer;

   localparam logic [15:0] RST_PC = 16'hFFFE;
   localparam logic [15:0] HALT   = 16'hFFFF;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        Run = 1'b0;
   logic        Instr_Ready = 1'b0;
   logic        Branch_Taken = 1'b0;
   logic [15:0] Branch_Target = 16'h0000;
   logic [7:0]  Mem_Data;
   logic [15:0] Mem_Addr;
   logic        Mem_Rd_En;
   logic [15:0] Instr_Out;
   logic [15:0] Instr_PC;
   logic        Instr_Valid;
   logic        Halted;

   int total = 0;
   int bad   = 0;

   fetch_sequencer #(.RESET_PC(RST_PC), .HALT_WORD(HALT)) dut (
      .clk(clk), .reset_n(reset_n), .Run(Run),
      .Mem_Addr(Mem_Addr), .Mem_Rd_En(Mem_Rd_En), .Mem_Data(Mem_Data),
      .Instr_Out(Instr_Out), .Instr_PC(Instr_PC), .Instr_Valid(Instr_Valid),
      .Instr_Ready(Instr_Ready), .Branch_Taken(Branch_Taken),
      .Branch_Target(Branch_Target), .Halted(Halted)
   );

   always #5 clk = ~clk;

   // Byte memory with one-cycle read latency; garbage when not read.
   logic [7:0] mem [0:65535];
   always @(posedge clk) Mem_Data <= Mem_Rd_En ? mem[Mem_Addr] : 8'($urandom);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] word_at(input logic [15:0] a);
      logic [15:0] b;
      b = a + 16'd1;
      return {mem[a], mem[b]};
   endfunction

   typedef struct packed {
      logic [15:0] pc;
      logic [15:0] word;
   } item_t;
   item_t exp_q[$];

   // Reference model: architectural PC plus a fetch countdown of three cycles.
   bit          m_idle   = 1'b1;
   bit          m_valid  = 1'b0;
   bit          m_halted = 1'b0;
   int          m_cnt    = 0;
   logic [15:0] m_pc     = RST_PC;

   always @(posedge clk) begin
      if (!reset_n) begin
         chk("presentation_missed", 32'(exp_q.size()), 32'd0);
         exp_q.delete();
         m_idle = 1'b1; m_valid = 1'b0; m_halted = 1'b0; m_cnt = 0; m_pc = RST_PC;
      end else if (m_idle) begin
         if (Branch_Taken) m_pc = Branch_Target & 16'hFFFE;
         if (Run) begin m_idle = 1'b0; m_cnt = 3; end
      end else if (Branch_Taken) begin
         m_pc = Branch_Target & 16'hFFFE;
         m_valid = 1'b0; m_halted = 1'b0; m_cnt = 3;
      end else if (m_valid) begin
         if (Instr_Ready) begin m_pc = m_pc + 16'd2; m_valid = 1'b0; m_cnt = 3; end
      end else if (!m_halted) begin
         m_cnt--;
         if (m_cnt == 0) begin
            if (word_at(m_pc) == HALT) m_halted = 1'b1;
            else begin
               m_valid = 1'b1;
               exp_q.push_back('{pc: m_pc, word: word_at(m_pc)});
            end
         end
      end
   end

   // Monitor: per-cycle status checks and scoreboard pop on each new presentation.
   item_t cur = '0;
   bit    prev_valid = 1'b0;
   always @(negedge clk) begin
      logic        m_rd;
      logic [15:0] m_addr;
      m_rd   = !m_idle && !m_valid && !m_halted && (m_cnt >= 2);
      m_addr = !m_rd ? 16'h0000 : (m_cnt == 3) ? m_pc : m_pc + 16'd1;
      chk("valid", 32'(Instr_Valid), 32'(m_valid));
      chk("halted", 32'(Halted), 32'(m_halted));
      chk("rd_en", 32'(Mem_Rd_En), 32'(m_rd));
      chk("mem_addr", 32'(Mem_Addr), 32'(m_addr));
      if (Instr_Valid === 1'b1 && !prev_valid) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_valid: got pc %h instr %h want none", Instr_PC, Instr_Out);
         end else cur = exp_q.pop_front();
      end
      if (Instr_Valid === 1'b1) begin
         chk("instr_out", 32'(Instr_Out), 32'(cur.word));
         chk("instr_pc", 32'(Instr_PC), 32'(cur.pc));
      end
      prev_valid = (Instr_Valid === 1'b1);
   end

   task automatic wait_valid(input int maxc, output int n);
      n = 0;
      while (Instr_Valid !== 1'b1 && n < maxc) begin
         @(negedge clk);
         n++;
      end
      chk("wait_valid_timeout", 32'(Instr_Valid), 32'd1);
   endtask

   task automatic expect_instr(input string name, input logic [15:0] w, input logic [15:0] p);
      int n;
      wait_valid(20, n);
      chk({name, "_latency"}, 32'(n), 32'd3);
      chk({name, "_word"}, 32'(Instr_Out), 32'(w));
      chk({name, "_pc"}, 32'(Instr_PC), 32'(p));
   endtask

   task automatic chk_reset_outputs(input string name);
      chk({name, "_out"}, 32'(Instr_Out), 32'd0);
      chk({name, "_pc"}, 32'(Instr_PC), 32'd0);
      chk({name, "_valid"}, 32'(Instr_Valid), 32'd0);
      chk({name, "_halted"}, 32'(Halted), 32'd0);
      chk({name, "_rd"}, 32'(Mem_Rd_En), 32'd0);
      chk({name, "_addr"}, 32'(Mem_Addr), 32'd0);
   endtask

   task automatic branch(input logic [15:0] t);
      Branch_Taken = 1'b1; Branch_Target = t;
      @(negedge clk);
      Branch_Taken = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] img [0:9];
      img = '{8'h31, 8'h12, 8'h34, 8'h13, 8'h01, 8'h40, 8'h02, 8'h41, 8'hFF, 8'hFF};
      for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);

      // Wrap-around fetch from RESET_PC = FFFE.
      mem[16'hFFFE] = 8'h31; mem[16'hFFFF] = 8'h12; mem[0] = 8'h34; mem[1] = 8'h13;
      Instr_Ready = 1'b1;
      repeat (3) @(negedge clk);
      chk_reset_outputs("reset");
      reset_n = 1'b1; Run = 1'b1;
      @(negedge clk);
      Run = 1'b0;
      expect_instr("wrap0", 16'h3112, 16'hFFFE);
      @(negedge clk);
      expect_instr("wrap1", 16'h3413, 16'h0000);

      // Load image, branch while idle to 0, then stream four instructions into halt.
      reset_n = 1'b0;
      for (int a = 0; a < 10; a++) mem[a] = img[a];
      @(negedge clk);
      reset_n = 1'b1;
      branch(16'h0000);
      repeat (3) @(negedge clk);
      chk("idle_after_branch_rd", 32'(Mem_Rd_En), 32'd0);
      Run = 1'b1;
      @(negedge clk);
      Run = 1'b0;
      expect_instr("seq0", 16'h3112, 16'h0000);
      @(negedge clk);
      expect_instr("seq1", 16'h3413, 16'h0002);
      @(negedge clk);
      expect_instr("seq2", 16'h0140, 16'h0004);
      @(negedge clk);
      expect_instr("seq3", 16'h0241, 16'h0006);
      repeat (4) @(negedge clk);
      chk("halt_flag", 32'(Halted), 32'd1);
      Run = 1'b1;
      @(negedge clk);
      Run = 1'b0;
      @(negedge clk);
      chk("halt_ignores_run", 32'(Halted), 32'd1);

      // Leave halt by branch, then stall decode for five cycles.
      Instr_Ready = 1'b0;
      branch(16'h0000);
      chk("halt_exit", 32'(Halted), 32'd0);
      expect_instr("stall0", 16'h3112, 16'h0000);
      repeat (5) begin
         @(negedge clk);
         chk("stall_hold_valid", 32'(Instr_Valid), 32'd1);
         chk("stall_hold_word", 32'(Instr_Out), 32'h3112);
      end
      Instr_Ready = 1'b1;
      @(negedge clk);
      expect_instr("stall1", 16'h3413, 16'h0002);

      // Branch coincident with acceptance, then an odd-target branch mid-fetch.
      branch(16'h0000);
      expect_instr("br_accept", 16'h3112, 16'h0000);
      repeat (2) @(negedge clk);
      branch(16'h0005);
      expect_instr("br_odd", 16'h0140, 16'h0004);

      // Reset while latching the low byte discards the partial fetch.
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      branch(16'h0000);
      Run = 1'b1;
      @(negedge clk);
      Run = 1'b0;
      repeat (2) @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      chk_reset_outputs("reset_latch");
      reset_n = 1'b1;
      branch(16'h0000);
      repeat (2) @(negedge clk);
      chk("reset_latch_no_valid", 32'(Instr_Valid), 32'd0);
      Run = 1'b1;
      @(negedge clk);
      Run = 1'b0;
      expect_instr("after_reset", 16'h3112, 16'h0000);

      // Random traffic; the model and scoreboard check every cycle.
      for (int c = 0; c < 4000; c++) begin
         int sel;
         reset_n      = ($urandom_range(0, 299) != 0);
         Run          = ($urandom_range(0, 9) == 0);
         Instr_Ready  = ($urandom_range(0, 9) < 7);
         Branch_Taken = ($urandom_range(0, 29) == 0);
         sel = $urandom_range(0, 3);
         if (sel == 0)      Branch_Target = 16'($urandom);
         else if (sel == 1) Branch_Target = 16'hFFFC + 16'($urandom_range(0, 3));
         else               Branch_Target = 16'($urandom_range(0, 11));
         @(negedge clk);
      end
      reset_n = 1'b1; Run = 1'b0; Branch_Taken = 1'b0; Instr_Ready = 1'b1;
      repeat (20) @(negedge clk);
      chk("drain", 32'(exp_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
